// File: rtl/fpga_core.sv
// fpga_core: board-level glue. Registers switches onto LEDs, counts completed
// XFCP frames, loops UART and GMII receive back to transmit, and passes the
// XFCP stream through a 2-entry FIFO. I2C is parked (bus released).
module fpga_core (
    input  logic       clk,
    input  logic       rst,

    input  logic       btnu,
    input  logic       btnl,
    input  logic       btnd,
    input  logic       btnr,
    input  logic       btnc,
    input  logic [3:0] sw,
    output logic [7:0] led,

    input  logic       i2c_scl_i,
    output logic       i2c_scl_o,
    output logic       i2c_scl_t,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       i2c_sda_t,

    input  logic       phy_gmii_clk,
    input  logic       phy_gmii_rst,
    input  logic       phy_gmii_clk_en,
    input  logic [7:0] phy_gmii_rxd,
    input  logic       phy_gmii_rx_dv,
    input  logic       phy_gmii_rx_er,
    output logic [7:0] phy_gmii_txd,
    output logic       phy_gmii_tx_en,
    output logic       phy_gmii_tx_er,
    output logic       phy_reset_n,
    input  logic       phy_int_n,

    input  logic       uart_rxd,
    input  logic       uart_cts,
    output logic       uart_txd,
    output logic       uart_rts,

    input  logic [7:0] xfcp_mgt_up_tdata,
    input  logic       xfcp_mgt_up_tvalid,
    output logic       xfcp_mgt_up_tready,
    input  logic       xfcp_mgt_up_tlast,
    input  logic       xfcp_mgt_up_tuser,

    output logic [7:0] xfcp_mgt_down_tdata,
    output logic       xfcp_mgt_down_tvalid,
    input  logic       xfcp_mgt_down_tready,
    output logic       xfcp_mgt_down_tlast,
    output logic       xfcp_mgt_down_tuser
);

    // Inputs the board exposes but this core does not use.
    logic unused_inputs;
    assign unused_inputs = ^{btnu, btnl, btnd, btnr, i2c_scl_i, i2c_sda_i,
                             phy_gmii_clk, phy_int_n, uart_cts};

    assign i2c_scl_o = 1'b1;
    assign i2c_scl_t = 1'b1;
    assign i2c_sda_o = 1'b1;
    assign i2c_sda_t = 1'b1;
    assign uart_rts  = 1'b0;

    // FIFO entry layout: {tdata, tlast, tuser}
    logic [9:0] fifo_mem [0:1];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       do_push;
    logic       do_pop;
    logic [9:0] head;

    logic [3:0] frame_cnt;
    logic [3:0] sw_reg;

    assign fifo_full  = (fifo_count == 2'd2);
    assign fifo_empty = (fifo_count == 2'd0);
    // A full FIFO refuses data even when it is being drained this cycle.
    assign do_push    = xfcp_mgt_up_tvalid && !fifo_full;
    assign do_pop     = !fifo_empty && xfcp_mgt_down_tready;
    assign head       = fifo_mem[rd_ptr];

    assign xfcp_mgt_up_tready   = !fifo_full;
    assign xfcp_mgt_down_tvalid = !fifo_empty;
    assign xfcp_mgt_down_tdata  = head[9:2];
    assign xfcp_mgt_down_tlast  = head[1];
    assign xfcp_mgt_down_tuser  = head[0];

    assign led = {frame_cnt, sw_reg};

    // FIFO storage and pointers; occupancy tracked explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= {xfcp_mgt_up_tdata, xfcp_mgt_up_tlast, xfcp_mgt_up_tuser};
                wr_ptr           <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame counter: clear wins over a same-cycle frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 4'd0;
        end else if (btnc) begin
            frame_cnt <= 4'd0;
        end else if (do_pop && head[1]) begin
            frame_cnt <= frame_cnt + 4'd1;
        end
    end

    // Switch capture, UART loopback and PHY reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_reg      <= 4'd0;
            uart_txd    <= 1'b1;
            phy_reset_n <= 1'b0;
        end else begin
            sw_reg      <= sw;
            uart_txd    <= uart_rxd;
            phy_reset_n <= 1'b1;
        end
    end

    // GMII loopback on clk, advancing only on enabled beats; local clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phy_gmii_txd   <= 8'd0;
            phy_gmii_tx_en <= 1'b0;
            phy_gmii_tx_er <= 1'b0;
        end else if (phy_gmii_rst) begin
            phy_gmii_txd   <= 8'd0;
            phy_gmii_tx_en <= 1'b0;
            phy_gmii_tx_er <= 1'b0;
        end else if (phy_gmii_clk_en) begin
            phy_gmii_txd   <= phy_gmii_rxd;
            phy_gmii_tx_en <= phy_gmii_rx_dv;
            phy_gmii_tx_er <= phy_gmii_rx_er;
        end
    end

endmodule

// File: tb/tb_fpga_core.sv
// tb_fpga_core: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of the board core.
module tb_fpga_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnu = 0, btnl = 0, btnd = 0, btnr = 0, btnc = 0;
    logic [3:0] sw = 0;
    logic [7:0] led;
    logic       i2c_scl_i = 1, i2c_sda_i = 1;
    logic       i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t;
    logic       phy_gmii_clk = 0, phy_gmii_rst = 0, phy_gmii_clk_en = 0;
    logic [7:0] phy_gmii_rxd = 0;
    logic       phy_gmii_rx_dv = 0, phy_gmii_rx_er = 0;
    logic [7:0] phy_gmii_txd;
    logic       phy_gmii_tx_en, phy_gmii_tx_er, phy_reset_n;
    logic       phy_int_n = 1;
    logic       uart_rxd = 1, uart_cts = 0;
    logic       uart_txd, uart_rts;
    logic [7:0] up_tdata = 0;
    logic       up_tvalid = 0, up_tready, up_tlast = 0, up_tuser = 0;
    logic [7:0] down_tdata;
    logic       down_tvalid, down_tready = 0, down_tlast, down_tuser;

    fpga_core dut (
        .clk(clk), .rst(rst),
        .btnu(btnu), .btnl(btnl), .btnd(btnd), .btnr(btnr), .btnc(btnc),
        .sw(sw), .led(led),
        .i2c_scl_i(i2c_scl_i), .i2c_scl_o(i2c_scl_o), .i2c_scl_t(i2c_scl_t),
        .i2c_sda_i(i2c_sda_i), .i2c_sda_o(i2c_sda_o), .i2c_sda_t(i2c_sda_t),
        .phy_gmii_clk(phy_gmii_clk), .phy_gmii_rst(phy_gmii_rst),
        .phy_gmii_clk_en(phy_gmii_clk_en), .phy_gmii_rxd(phy_gmii_rxd),
        .phy_gmii_rx_dv(phy_gmii_rx_dv), .phy_gmii_rx_er(phy_gmii_rx_er),
        .phy_gmii_txd(phy_gmii_txd), .phy_gmii_tx_en(phy_gmii_tx_en),
        .phy_gmii_tx_er(phy_gmii_tx_er), .phy_reset_n(phy_reset_n),
        .phy_int_n(phy_int_n),
        .uart_rxd(uart_rxd), .uart_cts(uart_cts), .uart_txd(uart_txd), .uart_rts(uart_rts),
        .xfcp_mgt_up_tdata(up_tdata), .xfcp_mgt_up_tvalid(up_tvalid),
        .xfcp_mgt_up_tready(up_tready), .xfcp_mgt_up_tlast(up_tlast),
        .xfcp_mgt_up_tuser(up_tuser),
        .xfcp_mgt_down_tdata(down_tdata), .xfcp_mgt_down_tvalid(down_tvalid),
        .xfcp_mgt_down_tready(down_tready), .xfcp_mgt_down_tlast(down_tlast),
        .xfcp_mgt_down_tuser(down_tuser)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [9:0] m_q[$];
    logic [3:0] m_cnt;
    logic [3:0] m_sw;
    logic [7:0] m_txd;
    logic       m_tx_en, m_tx_er, m_phy_n, m_uart;
    logic [7:0] out_log[$];
    logic       last_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt = 0; m_sw = 0; m_txd = 0; m_tx_en = 0; m_tx_er = 0;
        m_phy_n = 0; m_uart = 1;
    endtask

    task automatic compare_all();
        chk("led", {24'd0, led}, {24'd0, m_cnt, m_sw});
        chk("up_tready", {31'd0, up_tready}, (m_q.size() < 2) ? 1 : 0);
        chk("down_tvalid", {31'd0, down_tvalid}, (m_q.size() > 0) ? 1 : 0);
        if (m_q.size() > 0)
            chk("down_beat", {22'd0, down_tdata, down_tlast, down_tuser}, {22'd0, m_q[0]});
        chk("gmii_tx", {22'd0, phy_gmii_txd, phy_gmii_tx_en, phy_gmii_tx_er},
            {22'd0, m_txd, m_tx_en, m_tx_er});
        chk("phy_reset_n", {31'd0, phy_reset_n}, {31'd0, m_phy_n});
        chk("uart", {30'd0, uart_txd, uart_rts}, {30'd0, m_uart, 1'b0});
        chk("i2c", {28'd0, i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t}, 32'hF);
    endtask

    // Apply one clock edge with the inputs currently driven, then check at the falling edge.
    task automatic tick();
        bit pop, push;
        pop  = down_tready && (m_q.size() > 0);
        push = up_tvalid && (m_q.size() < 2);
        if (down_tvalid && down_tready) begin
            out_log.push_back(down_tdata);
            last_log.push_back(down_tlast);
        end
        if (btnc) m_cnt = 0;
        else if (pop && m_q[0][1]) m_cnt = 4'((m_cnt + 1) % 16);
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({up_tdata, up_tlast, up_tuser});
        m_sw = sw;
        m_uart = uart_rxd;
        m_phy_n = 1;
        if (phy_gmii_rst) begin
            m_txd = 0; m_tx_en = 0; m_tx_er = 0;
        end else if (phy_gmii_clk_en) begin
            m_txd = phy_gmii_rxd; m_tx_en = phy_gmii_rx_dv; m_tx_er = phy_gmii_rx_er;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        #1 chk("phy_n_held", {31'd0, phy_reset_n}, 0);
        tick();
        chk("phy_n_release", {31'd0, phy_reset_n}, 1);
    endtask

    initial begin
        logic [7:0] exp_bytes[$];
        int sent;
        model_reset();

        // Reset and idle
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        tick();
        chk("idle_led", {24'd0, led}, 0);
        chk("idle_phy_n", {31'd0, phy_reset_n}, 1);
        tick();

        // Switches, buttons ignored
        sw = 4'hA;
        tick();
        chk("sw_capture", {28'd0, led[3:0]}, 32'hA);
        for (int i = 0; i < 6; i++) begin
            {btnu, btnl, btnd, btnr} = 4'($urandom);
            tick();
        end
        chk("btn_no_effect", {24'd0, led}, 32'h0A);
        {btnu, btnl, btnd, btnr} = 4'd0;

        // 3-byte frame, sink always ready
        out_log.delete(); last_log.delete();
        down_tready = 1;
        exp_bytes = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            up_tvalid = 1; up_tdata = exp_bytes[i]; up_tlast = (i == 2); up_tuser = 0;
            tick();
        end
        up_tvalid = 0; up_tlast = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("frame_len", out_log.size(), 3);
        for (int i = 0; i < 3 && i < out_log.size(); i++) begin
            chk("frame_byte", {24'd0, out_log[i]}, {24'd0, exp_bytes[i]});
            chk("frame_last", {31'd0, last_log[i]}, (i == 2) ? 1 : 0);
        end
        chk("frame_count", {28'd0, led[7:4]}, 1);

        // Backpressure
        out_log.delete(); last_log.delete();
        down_tready = 0;
        exp_bytes = '{8'hA1, 8'hB2, 8'hC3};
        sent = 0;
        for (int cyc = 0; cyc < 20 && sent < 3; cyc++) begin
            up_tvalid = 1; up_tdata = exp_bytes[sent]; up_tlast = (sent == 2);
            if (up_tready) sent++;
            tick();
            if (cyc == 3) begin
                chk("bp_tready_low", {31'd0, up_tready}, 0);
                chk("bp_sent", sent, 2);
                down_tready = 1;
            end
        end
        chk("bp_all_sent", sent, 3);
        up_tvalid = 0; up_tlast = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_len", out_log.size(), 3);
        for (int i = 0; i < 3 && i < out_log.size(); i++)
            chk("bp_byte", {24'd0, out_log[i]}, {24'd0, exp_bytes[i]});

        // GMII enable gating and clear
        phy_gmii_rxd = 8'h55; phy_gmii_rx_dv = 1;
        for (int i = 0; i < 6; i++) begin
            phy_gmii_clk_en = i[0];
            tick();
            if (i == 0) chk("gmii_hold", {31'd0, phy_gmii_tx_en}, 0);
        end
        chk("gmii_txd", {24'd0, phy_gmii_txd}, 32'h55);
        phy_gmii_rst = 1; phy_gmii_clk_en = 1;
        tick();
        chk("gmii_clear", {23'd0, phy_gmii_txd, phy_gmii_tx_en}, 0);
        phy_gmii_rst = 0; phy_gmii_clk_en = 0; phy_gmii_rx_dv = 0;

        // Counter wrap after 16 frames
        btnc = 1; tick(); btnc = 0;
        down_tready = 1;
        for (int i = 0; i < 16; i++) begin
            up_tvalid = 1; up_tdata = 8'(i); up_tlast = 1;
            tick();
        end
        up_tvalid = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("cnt_wrap", {28'd0, led[7:4]}, 0);

        // Clear collides with a frame completion
        down_tready = 0;
        up_tvalid = 1; up_tdata = 8'h77; up_tlast = 1; tick();
        up_tvalid = 1; up_tdata = 8'h78; up_tlast = 1; tick();
        up_tvalid = 0;
        down_tready = 1; tick();
        chk("cnt_before_clr", {28'd0, led[7:4]}, 1);
        btnc = 1; tick();
        btnc = 0;
        chk("cnt_clr_wins", {28'd0, led[7:4]}, 0);
        tick();

        // Mid-frame reset discards FIFO contents
        down_tready = 0;
        up_tvalid = 1; up_tdata = 8'hE1; up_tlast = 0; tick();
        up_tdata = 8'hE2; tick();
        up_tvalid = 0;
        apply_reset();
        chk("rst_fifo_empty", {31'd0, down_tvalid}, 0);
        down_tready = 1;
        out_log.delete();
        for (int i = 0; i < 3; i++) tick();
        chk("rst_no_output", out_log.size(), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            up_tvalid = 1'($urandom); up_tdata = 8'($urandom);
            up_tlast = ($urandom_range(0, 3) == 0); up_tuser = 1'($urandom);
            down_tready = 1'($urandom);
            sw = 4'($urandom);
            {btnu, btnl, btnd, btnr} = 4'($urandom);
            btnc = ($urandom_range(0, 15) == 0);
            phy_gmii_clk_en = 1'($urandom); phy_gmii_rst = ($urandom_range(0, 15) == 0);
            phy_gmii_rxd = 8'($urandom); phy_gmii_rx_dv = 1'($urandom); phy_gmii_rx_er = 1'($urandom);
            uart_rxd = 1'($urandom);
            if ($urandom_range(0, 99) == 0) apply_reset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpga_core.md
FPGA_CORE -- requirements
Module: fpga_core

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high: clk and rst.
REQ-003 clk  in  1  system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 btnu, btnl, btnd, btnr  in  1 each  push buttons; ignored.
REQ-006 btnc  in  1  synchronous clear of the frame counter.
REQ-007 sw  in  4  DIP switches.
REQ-008 led  out  8  status: [7:4] frame counter, [3:0] registered sw.
REQ-009 i2c_scl_i, i2c_sda_i  in  1 each  I2C pin inputs; ignored.
REQ-010 i2c_scl_o, i2c_scl_t, i2c_sda_o, i2c_sda_t  out  1 each  I2C drive/tristate (t=1 releases).
REQ-011 phy_gmii_clk  in  1  ignored; the GMII path runs on clk.
REQ-012 phy_gmii_rst  in  1  synchronous clear of the GMII transmit registers.
REQ-013 phy_gmii_clk_en  in  1  GMII beat enable.
REQ-014 phy_gmii_rxd  in  8, phy_gmii_rx_dv  in  1, phy_gmii_rx_er  in  1  GMII receive.
REQ-015 phy_gmii_txd  out  8, phy_gmii_tx_en  out  1, phy_gmii_tx_er  out  1  GMII transmit.
REQ-016 phy_reset_n  out  1  PHY reset, active-low.
REQ-017 phy_int_n  in  1  PHY interrupt; ignored.
REQ-018 uart_rxd  in  1, uart_cts  in  1 (ignored); uart_txd  out  1, uart_rts  out  1.
REQ-019 xfcp_mgt_up_tdata  in  8, _tvalid  in  1, _tready  out  1, _tlast  in  1, _tuser  in  1  AXI-Stream sink.
REQ-020 xfcp_mgt_down_tdata  out  8, _tvalid  out  1, _tready  in  1, _tlast  out  1, _tuser  out  1  AXI-Stream source.

Function
REQ-021 I2C outputs SHALL be constant 1 (scl_o=sda_o=scl_t=sda_t=1, bus released).
REQ-022 led[3:0] SHALL register sw every cycle (1-cycle latency).
REQ-023 led[7:4] SHALL be a 4-bit counter, +1 per down handshake (tvalid&tready) with tlast=1, wrapping 15->0.
REQ-024 btnc=1 SHALL clear the counter on the next edge; a counter increment in the same cycle is discarded.
REQ-025 GMII: on each edge with phy_gmii_clk_en=1, txd<=rxd, tx_en<=rx_dv, tx_er<=rx_er; with clk_en=0, outputs hold.
REQ-026 phy_gmii_rst=1 SHALL clear txd/tx_en/tx_er to 0 on the next edge, overriding clk_en.
REQ-027 phy_reset_n SHALL be a register that is 0 in reset and becomes 1 on the first edge after rst deasserts.
REQ-028 uart_txd SHALL be uart_rxd registered (1-cycle loopback).
REQ-029 uart_rts SHALL be constant 0.
REQ-030 XFCP path SHALL be a 2-entry FIFO of {tdata,tlast,tuser}; up_tready=not full; down_tvalid=not empty; down outputs are driven from the head entry.
REQ-031 Up-side data accepted at edge N SHALL be visible on down at edge N (down_tvalid=1 in cycle N+1); order preserved; no data loss or duplication.
REQ-032 Simultaneous push and pop SHALL keep the occupancy unchanged; when full, up_tready=0 and no push occurs even if a pop occurs that cycle.
REQ-033 down_tdata/tlast/tuser SHALL be stable while down_tvalid=1 and down_tready=0.

Reset
REQ-034 rst=1 SHALL asynchronously force: FIFO empty (down_tvalid=0, up_tready=1), counter=0, led=0, GMII tx outputs=0, phy_reset_n=0, uart_txd=1.
REQ-035 Reset mid-frame SHALL discard FIFO contents; no partial frame is emitted afterwards.

Verification
REQ-036 Reset, then idle -> led=0x0, up_tready=1, down_tvalid=0, phy_reset_n=1 one edge after release, I2C outputs all 1.
REQ-037 sw=4'hA -> led[3:0]=4'hA one cycle later; btnu..btnr toggling -> no change.
REQ-038 Push 3-byte frame 0x11,0x22,0x33 (tlast on 0x33) with down_tready=1 -> same bytes out in order, tlast on 0x33 only, led[7:4]=1.
REQ-039 down_tready=0, push 3 bytes -> up_tready drops after 2 accepted; after down_tready=1, all 3 bytes emerge in order.
REQ-040 phy_gmii_clk_en alternating, rxd=0x55, rx_dv=1 -> txd=0x55, tx_en=1 updated only on enabled edges; phy_gmii_rst=1 -> txd=0, tx_en=0.
REQ-041 16 single-byte tlast frames -> led[7:4] wraps to 0; btnc=1 asserted with a frame completion in the same cycle -> counter=0.
